// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide main memory between the icache and dcache.
// Granted transactions are forwarded unchanged; each requester sees a memory-style busywait.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state_r;
    logic   started_r;
    logic   last_grant_r;
    logic   i_req_s;
    logic   d_req_s;
    logic   done_s;

    assign i_req_s    = i_read;
    assign d_req_s    = d_read | d_write;
    assign i_readdata = mem_readdata;
    assign d_readdata = mem_readdata;

    // Completion: memory must have been seen busy before its fall counts as done.
    always_comb begin
        done_s = 1'b0;
        if ((state_r == GRANT_I) || (state_r == GRANT_D)) begin
            done_s = started_r & ~mem_busywait;
        end else begin
            done_s = 1'b0;
        end
    end

    // Per-requester stall: released only in that requester's own done cycle.
    always_comb begin
        i_busywait = i_req_s & ~((state_r == GRANT_I) & done_s);
        d_busywait = d_req_s & ~((state_r == GRANT_D) & done_s);
    end

    // Memory-side drive decoded from the grant state; write wins over read for the dcache.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = {ADDR_W{1'b0}};
        mem_writedata = {DATA_W{1'b0}};
        case (state_r)
            GRANT_I: begin
                mem_read    = 1'b1;
                mem_address = i_address;
            end
            GRANT_D: begin
                mem_read      = d_read & ~d_write;
                mem_write     = d_write;
                mem_address   = d_address;
                mem_writedata = d_writedata;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    // Grant FSM: ties go to whoever was not granted last; a grant is never aborted except by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            started_r    <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_req_s && (!d_req_s || last_grant_r)) begin
                        state_r      <= GRANT_I;
                        started_r    <= 1'b0;
                        last_grant_r <= 1'b0;
                    end else if (d_req_s) begin
                        state_r      <= GRANT_D;
                        started_r    <= 1'b0;
                        last_grant_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (done_s) begin
                        state_r <= IDLE;
                    end else if (mem_busywait) begin
                        started_r <= 1'b1;
                    end else begin
                        started_r <= started_r;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    started_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: requester tasks queue expectations,
// a negedge monitor checks each completion against a reference memory and fairness rules.
module tb_mem_arbiter;

    typedef struct packed {
        logic [5:0]   addr;
        logic         wr;
        logic [127:0] data;
    } dtx_t;

    logic         clock;
    logic         reset;
    logic         i_read;
    logic [5:0]   i_address;
    logic [127:0] i_readdata;
    logic         i_busywait;
    logic         d_read;
    logic         d_write;
    logic [5:0]   d_address;
    logic [127:0] d_writedata;
    logic [127:0] d_readdata;
    logic         d_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [5:0]   mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int total = 0;
    int bad   = 0;

    logic [127:0] mem_arr [64];
    logic [127:0] ref_mem [64];
    logic [5:0]   iq [$];
    dtx_t         dq [$];
    int           log_q [$];
    int           fixed_cnt  = 0;
    int           fixed_late = -1;

    mem_arbiter #(.ADDR_W(6), .DATA_W(128)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_readdata   (i_readdata),
        .i_busywait   (i_busywait),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_writedata  (d_writedata),
        .d_readdata   (d_readdata),
        .d_busywait   (d_busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory model: raises busywait (optionally one cycle late) for a few cycles per transaction.
    initial begin
        int mstate;
        int cnt;
        int late;
        mem_busywait = 1'b0;
        mem_readdata = 128'd0;
        mstate = 0;
        cnt = 0;
        forever begin
            @(posedge clock); #1;
            case (mstate)
                0: if (mem_read || mem_write) begin
                    cnt  = (fixed_cnt > 0) ? fixed_cnt : int'($urandom_range(6, 1));
                    late = (fixed_late >= 0) ? fixed_late : int'($urandom_range(1, 0));
                    if (late != 0) mstate = 1;
                    else begin mem_busywait = 1'b1; mstate = 2; end
                end
                1: if (!(mem_read || mem_write)) mstate = 0;
                   else begin mem_busywait = 1'b1; mstate = 2; end
                2: if (!(mem_read || mem_write)) begin
                       mem_busywait = 1'b0; mstate = 0;
                   end else if (cnt > 1) cnt--;
                   else begin
                       mem_busywait = 1'b0;
                       if (mem_write) mem_arr[mem_address] = mem_writedata;
                       else mem_readdata = mem_arr[mem_address];
                       mstate = 3;
                   end
                default: mstate = 0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each completion and checks protocol invariants.
    initial begin
        logic prev_done;
        logic busy_seen;
        logic idone;
        logic ddone;
        int   i_foreign;
        int   d_foreign;
        logic [5:0] a;
        dtx_t e;
        prev_done = 1'b0; busy_seen = 1'b0; i_foreign = 0; d_foreign = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_done = 1'b0; busy_seen = 1'b0; i_foreign = 0; d_foreign = 0;
            end else begin
                idone = i_read && !i_busywait;
                ddone = (d_read || d_write) && !d_busywait;
                chk("strobe_excl", {127'd0, mem_read && mem_write}, 128'd0);
                chk("one_done", {127'd0, idone && ddone}, 128'd0);
                if (prev_done) begin
                    chk("gap_read", {127'd0, mem_read}, 128'd0);
                    chk("gap_write", {127'd0, mem_write}, 128'd0);
                    chk("gap_addr", {122'd0, mem_address}, 128'd0);
                    chk("gap_wdata", mem_writedata, 128'd0);
                end
                if (!i_read) chk("i_bw_noreq", {127'd0, i_busywait}, 128'd0);
                if (!(d_read || d_write)) chk("d_bw_noreq", {127'd0, d_busywait}, 128'd0);
                if (idone) begin
                    chk("i_busy_seen", {127'd0, busy_seen}, 128'd1);
                    chk("i_fair", {127'd0, i_foreign > 1}, 128'd0);
                    i_foreign = 0;
                    if (d_read || d_write) d_foreign++;
                    if (iq.size() == 0) chk("i_unexpected", 128'd1, 128'd0);
                    else begin
                        a = iq.pop_front();
                        chk("i_mem_read", {127'd0, mem_read}, 128'd1);
                        chk("i_mem_write", {127'd0, mem_write}, 128'd0);
                        chk("i_addr", {122'd0, mem_address}, {122'd0, a});
                        chk("i_rdata", i_readdata, ref_mem[a]);
                    end
                    log_q.push_back(0);
                end
                if (ddone) begin
                    chk("d_busy_seen", {127'd0, busy_seen}, 128'd1);
                    chk("d_fair", {127'd0, d_foreign > 1}, 128'd0);
                    d_foreign = 0;
                    if (i_read) i_foreign++;
                    if (dq.size() == 0) chk("d_unexpected", 128'd1, 128'd0);
                    else begin
                        e = dq.pop_front();
                        chk("d_mem_write", {127'd0, mem_write}, {127'd0, e.wr});
                        chk("d_mem_read", {127'd0, mem_read}, {127'd0, ~e.wr});
                        chk("d_addr", {122'd0, mem_address}, {122'd0, e.addr});
                        if (e.wr) begin
                            chk("d_wdata", mem_writedata, e.data);
                            ref_mem[e.addr] = e.data;
                        end else begin
                            chk("d_rdata", d_readdata, ref_mem[e.addr]);
                        end
                    end
                    log_q.push_back(1);
                end
                if (idone || ddone) busy_seen = 1'b0;
                else if (mem_busywait && (mem_read || mem_write)) busy_seen = 1'b1;
                else busy_seen = busy_seen;
                prev_done = idone || ddone;
            end
        end
    end

    task automatic i_txn(input logic [5:0] a);
        int t;
        i_address = a;
        i_read = 1'b1;
        iq.push_back(a);
        t = 0;
        @(negedge clock);
        while (i_busywait && t < 300) begin @(negedge clock); t++; end
        chk("i_timeout", {127'd0, i_busywait}, 128'd0);
        @(posedge clock); #1;
        i_read = 1'b0;
    endtask

    task automatic d_txn(input logic [5:0] a, input logic wr, input logic both, input logic [127:0] data);
        int t;
        dtx_t e;
        d_address = a;
        d_writedata = data;
        d_write = wr;
        d_read = wr ? both : 1'b1;
        e.addr = a; e.wr = wr; e.data = data;
        dq.push_back(e);
        t = 0;
        @(negedge clock);
        while (d_busywait && t < 300) begin @(negedge clock); t++; end
        chk("d_timeout", {127'd0, d_busywait}, 128'd0);
        @(posedge clock); #1;
        d_read = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin @(posedge clock); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v;
        int t;
        for (int i = 0; i < 64; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        mem_arr[5] = {4{32'hA5A5A5A5}};
        ref_mem[5] = {4{32'hA5A5A5A5}};
        reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = 6'd0; d_address = 6'd0; d_writedata = 128'd0;

        // Reset state, including busywait following a request while held in reset.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
        chk("rst_mem_write", {127'd0, mem_write}, 128'd0);
        chk("rst_mem_addr", {122'd0, mem_address}, 128'd0);
        chk("rst_i_bw", {127'd0, i_busywait}, 128'd0);
        chk("rst_d_bw", {127'd0, d_busywait}, 128'd0);
        i_read = 1'b1;
        #1;
        chk("rst_i_bw_req", {127'd0, i_busywait}, 128'd1);
        @(posedge clock); #1;
        chk("rst_no_grant", {127'd0, mem_read}, 128'd0);
        i_read = 1'b0;
        reset = 1'b0;

        // Contention right after reset: icache first, then strict alternation.
        log_q.delete();
        fork
            begin i_txn(6'h01); i_txn(6'h02); end
            begin d_txn(6'h03, 1'b0, 1'b0, 128'd0); d_txn(6'h04, 1'b0, 1'b0, 128'd0); end
        join
        chk("cont_count", log_q.size(), 128'd4);
        if (log_q.size() == 4) begin
            chk("cont_g0", log_q[0], 128'd0);
            chk("cont_g1", log_q[1], 128'd1);
            chk("cont_g2", log_q[2], 128'd0);
            chk("cont_g3", log_q[3], 128'd1);
        end

        // Single icache read, memory busy five cycles.
        idle_cycles(2);
        fixed_cnt = 5; fixed_late = 0;
        i_txn(6'h05);
        chk("i05_data", i_readdata, {4{32'hA5A5A5A5}});

        // dcache write-back, then write with read also high, then read back.
        fixed_cnt = 0; fixed_late = -1;
        idle_cycles(1);
        d_txn(6'h3F, 1'b1, 1'b0, 128'h0123456789ABCDEF0123456789ABCDEF);
        d_txn(6'h3F, 1'b1, 1'b1, 128'hFEDCBA9876543210FEDCBA9876543210);
        d_txn(6'h3F, 1'b0, 1'b0, 128'd0);

        // Memory raising busywait one cycle late.
        fixed_late = 1;
        idle_cycles(1);
        i_txn(6'h3F);
        fixed_late = -1;

        // Reset in the middle of a dcache write-back.
        fixed_cnt = 6; fixed_late = 0;
        idle_cycles(1);
        d_address = 6'h2A; d_writedata = 128'h5; d_write = 1'b1; d_read = 1'b0;
        t = 0;
        do begin @(negedge clock); t++; end while (!mem_busywait && t < 50);
        chk("mid_busy", {127'd0, mem_busywait}, 128'd1);
        @(posedge clock); #1;
        reset = 1'b1; d_write = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_read", {127'd0, mem_read}, 128'd0);
        chk("mid_rst_write", {127'd0, mem_write}, 128'd0);
        chk("mid_rst_addr", {122'd0, mem_address}, 128'd0);
        chk("mid_rst_wdata", mem_writedata, 128'd0);
        fixed_cnt = 0; fixed_late = -1;
        @(posedge clock); #1;
        log_q.delete();
        i_txn(6'h11);
        chk("post_rst_grant", log_q.size(), 128'd1);

        // Randomized concurrent traffic from both caches.
        fork
            for (int n = 0; n < 30; n++) begin
                idle_cycles($urandom_range(3, 0));
                i_txn(6'($urandom_range(63, 0)));
            end
            for (int n = 0; n < 30; n++) begin
                logic wr;
                idle_cycles($urandom_range(3, 0));
                wr = 1'($urandom_range(1, 0));
                d_txn(6'($urandom_range(63, 0)), wr, 1'($urandom_range(1, 0)),
                      {$urandom, $urandom, $urandom, $urandom});
            end
        join

        idle_cycles(3);
        chk("iq_empty", iq.size(), 128'd0);
        chk("dq_empty", dq.size(), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
